timealign_conv_sched: RTL

- Sequences the two-stage converter and time-alignment datapath.
- On a start request it issues a paced burst of stage-1 and stage-2 sample strobes and tracks each sample through the aligner latency.
- Captures aligned 6-bit words `{MSB[2:0], LSB[2:0]}` into a small output buffer, presented downstream with valid/ready.
- Credit-based pacing guarantees the buffer never overflows under backpressure.

---
 rtl/timealign_sched_pkg.sv | 27 ++
 rtl/timealign_out_fifo.sv | 60 ++++++
 rtl/timealign_conv_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/timealign_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package  : timealign_sched_pkg
// Desc     : Shared state encoding, word widths and parameter defaults for the
//            converter / time-alignment scheduler.
// Revision : 1.0
// ============================================================================
package timealign_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int MSB_W  = 3;
   localparam int LSB_W  = 3;
   localparam int DATA_W = MSB_W + LSB_W;

   localparam int c_DEF_ALIGN_LAT  = 1;
   localparam int c_DEF_SAMPLE_DIV = 2;
   localparam int c_DEF_BUF_DEPTH  = 4;
   localparam int c_DEF_CNT_W      = 8;

endpackage
`default_nettype wire

// File: rtl/timealign_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : timealign_out_fifo
// Desc     : Small power-of-two FIFO holding aligned words; exposes occupancy
//            and the head entry combinationally.
// Revision : 1.0
// ============================================================================
module timealign_out_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [WIDTH-1:0]         head_o
);
   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_pop;

   // Producer is credit-limited, so a push never lands on a full FIFO unless
   // a pop frees the slot in the same cycle.
   assign w_pop = pop_i && (r_count != '0);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (push_i) begin
            r_mem[r_wr_ptr] <= push_data_i;
            r_wr_ptr        <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({push_i, w_pop})
            2'b10:   r_count <= r_count + (c_AW+1)'(1);
            2'b01:   r_count <= r_count - (c_AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign count_o = r_count;
   assign head_o  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/timealign_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : timealign_conv_sched
// Desc     : Issues paced stage-1/stage-2 strobes, tracks samples through the
//            aligner latency and buffers aligned words for a valid/ready sink.
//            Optional stall counter enabled by TIMEALIGN_SCHED_STALL_STATS_EN.
// Revision : 1.0
// ============================================================================
module timealign_conv_sched
   import timealign_sched_pkg::*;
#(
   parameter int ALIGN_LAT  = c_DEF_ALIGN_LAT,
   parameter int SAMPLE_DIV = c_DEF_SAMPLE_DIV,
   parameter int BUF_DEPTH  = c_DEF_BUF_DEPTH,
   parameter int CNT_W      = c_DEF_CNT_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  burst_len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              s1_strobe_o,
   output logic              s2_strobe_o,
   input  logic [DATA_W-1:0] align_dout_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [CNT_W-1:0]  sample_cnt_o
`ifdef TIMEALIGN_SCHED_STALL_STATS_EN
   ,
   output logic [15:0]       stall_cnt_o
`endif
);
   localparam int c_PIPE_LEN = 1 + ALIGN_LAT;
   localparam int c_CW       = $clog2(BUF_DEPTH) + 1;

   state_t                r_state;
   state_t                w_next_state;
   logic [CNT_W-1:0]      r_burst_len;
   logic [CNT_W-1:0]      r_sample_cnt;
   logic [4:0]            r_pace;
   logic                  r_s1_strobe;
   logic                  r_s2_strobe;
   logic                  r_done;
   logic [c_PIPE_LEN-1:0] r_vpipe;
   logic [c_CW-1:0]       w_buf_count;
   logic [DATA_W-1:0]     w_head;
   logic [3:0]            w_in_flight;
   logic [4:0]            w_occupancy;
   logic                  w_start_acc;
   logic                  w_pace_ok;
   logic                  w_credit_ok;
   logic                  w_fire;
   logic                  w_last;
   logic                  w_pop;
   logic                  w_drained;

   // The registered strobe is counted as in flight so that back-to-back
   // decisions can never over-commit buffer slots.
   always_comb begin
      w_in_flight = 4'(r_s1_strobe);
      for (int i = 0; i < c_PIPE_LEN; i++) begin
         w_in_flight = w_in_flight + 4'(r_vpipe[i]);
      end
   end

   assign w_start_acc = (r_state == IDLE) && start_i;
   assign w_pace_ok   = (r_pace == 5'd0);
   assign w_occupancy = 5'(w_in_flight) + 5'(w_buf_count);
   assign w_credit_ok = (w_occupancy < 5'(BUF_DEPTH));
   assign w_fire      = (r_state == RUN) && w_pace_ok && w_credit_ok;
   assign w_last      = ((r_sample_cnt + CNT_W'(1)) == r_burst_len);
   assign w_pop       = m_valid_o && m_ready_i;
   assign w_drained   = !r_s1_strobe && (r_vpipe == '0) && (w_buf_count == '0);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start_i) w_next_state = (burst_len_i == '0) ? DONE : RUN;
         RUN:     if (w_fire && w_last) w_next_state = DRAIN;
         DRAIN:   if (w_drained) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_burst_len  <= '0;
         r_sample_cnt <= '0;
         r_pace       <= '0;
         r_s1_strobe  <= 1'b0;
         r_s2_strobe  <= 1'b0;
         r_done       <= 1'b0;
         r_vpipe      <= '0;
      end else begin
         r_s1_strobe <= w_fire;
         r_s2_strobe <= r_s1_strobe;
         r_done      <= (r_state == DONE);
         r_vpipe     <= {r_vpipe[c_PIPE_LEN-2:0], r_s1_strobe};
         if (w_start_acc) begin
            r_burst_len  <= burst_len_i;
            r_sample_cnt <= '0;
            r_pace       <= '0;
         end else if (w_fire) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            r_pace       <= 5'(SAMPLE_DIV - 1);
         end else if (r_pace != 5'd0) begin
            r_pace <= r_pace - 5'd1;
         end
      end
   end

   timealign_out_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (DATA_W)
   ) u_out_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .push_i      (r_vpipe[c_PIPE_LEN-1]),
      .push_data_i (align_dout_i),
      .pop_i       (w_pop),
      .count_o     (w_buf_count),
      .head_o      (w_head)
   );

`ifdef TIMEALIGN_SCHED_STALL_STATS_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_stall_cnt <= '0;
      end else if (w_start_acc) begin
         r_stall_cnt <= '0;
      end else if ((r_state == RUN) && w_pace_ok && !w_credit_ok &&
                   (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

   assign busy_o       = (r_state == RUN) || (r_state == DRAIN);
   assign done_o       = r_done;
   assign s1_strobe_o  = r_s1_strobe;
   assign s2_strobe_o  = r_s2_strobe;
   assign m_valid_o    = (w_buf_count != '0);
   assign m_data_o     = w_head;
   assign sample_cnt_o = r_sample_cnt;

endmodule
`default_nettype wire
